fpu_dispatch_top: RTL
=====================

Name: fpu_dispatch_top

Overview:
Multi-channel front end for the shared FPU core. NUM_CH independent requesters each present operand pairs and an operation code. A round-robin arbiter serialises these requests onto the single core through its start/ready handshake. Each result is tagged with its source channel and queued in a result FIFO that drains over a valid/ready port. The block replaces the single-requester top level wherever several datapaths share one FPU.

Parameters:
REG_SIZE, 32, operand/result width in bits
OP_BITS, 2, operation code width
NUM_CH, 4, number of requester channels (2..8)
CH_BITS, 2, channel tag width; must equal ceil(log2(NUM_CH)), minimum 1
FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_CH  per-channel request present
req_ready  out  NUM_CH  per-channel accept; one-hot or zero
req_a  in  NUM_CH*REG_SIZE  operand A; channel i in bits [i*REG_SIZE +: REG_SIZE]
req_b  in  NUM_CH*REG_SIZE  operand B, same packing
req_op  in  NUM_CH*OP_BITS  operation code, same packing
core_start  out  1  one-cycle start pulse to the FPU core
core_a  out  REG_SIZE  registered operand A to the core
core_b  out  REG_SIZE  registered operand B to the core
core_op  out  OP_BITS  registered operation code to the core
core_res  in  REG_SIZE  core result, valid while core_ready is high
core_ready  in  1  core done; one-cycle pulse
rsp_valid  out  1  result FIFO not empty
rsp_ready  in  1  consumer accepts the head entry
rsp_res  out  REG_SIZE  head result
rsp_ch  out  CH_BITS  head channel tag
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous): FSM to IDLE; rr_ptr=0; FIFO empty (count=0); all outputs 0, including core_a, core_b and core_op. A reset mid-operation abandons the in-flight request. A core_ready arriving after reset is ignored.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - space = (fifo_count < FIFO_DEPTH).
  - When space is true and any req_valid is high, grant the first valid channel searching upward from rr_ptr, wrapping modulo NUM_CH.
  - req_ready[grant]=1 (combinational) for that cycle only.
  - On the same edge: latch the operands and op into the core_* registers, latch the grant into cur_ch, set rr_ptr=(grant+1) mod NUM_CH, go to ISSUE.
  - When space is false, req_ready=0 for all channels and the FSM stays in IDLE.
- ISSUE: core_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold core_a, core_b and core_op stable.
  - On core_ready=1: push {cur_ch, core_res} into the FIFO; go to IDLE.
  - No timeout.
- core_ready in IDLE or ISSUE is ignored and causes no push.
- Throughput: one op per (L+2) cycles, where L = cycles from core_start to core_ready (L>=1).
- Latency: acceptance edge T; core_start high in cycle T+1; FIFO push at edge T+1+L; rsp_valid rises in the next cycle if the FIFO was empty.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count; pointers wrap at FIFO_DEPTH.
  - Pop when rsp_valid && rsp_ready.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
  - A push never occurs while full, because space is checked before accepting and at most one op is in flight.
  - rsp_res and rsp_ch show the head entry; they must hold stable while rsp_valid && !rsp_ready.
- busy=1 in ISSUE and WAIT.

Test Plan:
- Single request: ch2 a=0x3F800000, b=0x40000000, op=0; core model returns 0x40400000 with L=3 -> req_ready[2] one cycle; core_start 1 cycle later; rsp_valid with rsp_ch=2, rsp_res=0x40400000 exactly L+2 cycles after acceptance.
- Round robin: all 4 channels hold req_valid; core L=1; rsp_ready=1 -> grant order 0,1,2,3,0 and responses tagged in the same order; no channel granted twice within 4 grants.
- Backpressure: rsp_ready=0, 6 requests pending, FIFO_DEPTH=4 -> exactly 4 results queued, then req_ready stays 0 and busy=0. Raising rsp_ready drains in order, and the remaining 2 requests are accepted as space frees.
- Simultaneous push/pop: FIFO holds 1 entry, rsp_ready=1 in the same cycle as core_ready -> count stays 1; head advances to the new entry.
- Spurious core_ready in IDLE -> no FIFO change, rsp_valid stays 0.
- Reset in WAIT: assert rst 2 cycles after core_start, then pulse core_ready -> FIFO empty, rr_ptr=0, no response; the next request on ch0 is granted normally.

Source files
------------

// File: rtl/fpu_dispatch_top.sv
// Multi-channel front end for the shared FPU core: round-robin arbitration of
// NUM_CH requesters onto one start/ready core, with results tagged and queued.
module fpu_dispatch_top #(
    parameter int REG_SIZE   = 32,
    parameter int OP_BITS    = 2,
    parameter int NUM_CH     = 4,
    parameter int CH_BITS    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*REG_SIZE-1:0]   req_a,
    input  logic [NUM_CH*REG_SIZE-1:0]   req_b,
    input  logic [NUM_CH*OP_BITS-1:0]    req_op,
    output logic                         core_start,
    output logic [REG_SIZE-1:0]          core_a,
    output logic [REG_SIZE-1:0]          core_b,
    output logic [OP_BITS-1:0]           core_op,
    input  logic [REG_SIZE-1:0]          core_res,
    input  logic                         core_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [REG_SIZE-1:0]          rsp_res,
    output logic [CH_BITS-1:0]           rsp_ch,
    output logic                         busy
);

    localparam int PTR_BITS  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam int ENTRY_W   = CH_BITS + REG_SIZE;
    localparam logic [CH_BITS:0]    CH_COUNT  = (CH_BITS+1)'(NUM_CH);
    localparam logic [CH_BITS-1:0]  LAST_CH   = CH_BITS'(NUM_CH - 1);
    localparam logic [CNT_BITS-1:0] FIFO_FULL = CNT_BITS'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state_reg;
    logic [CH_BITS-1:0]    rr_ptr_reg;
    logic [CH_BITS-1:0]    cur_ch_reg;
    logic                  core_start_reg;
    logic [REG_SIZE-1:0]   core_a_reg;
    logic [REG_SIZE-1:0]   core_b_reg;
    logic [OP_BITS-1:0]    core_op_reg;

    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_reg;
    logic [PTR_BITS-1:0]   rd_ptr_reg;
    logic [CNT_BITS-1:0]   count_reg;

    logic [REG_SIZE-1:0]   chan_a  [NUM_CH];
    logic [REG_SIZE-1:0]   chan_b  [NUM_CH];
    logic [OP_BITS-1:0]    chan_op [NUM_CH];

    logic                  grant_found;
    logic [CH_BITS-1:0]    grant_ch;
    logic [CH_BITS:0]      scan_idx;
    logic                  space;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [CH_BITS-1:0]    rr_next;
    logic [ENTRY_W-1:0]    head_entry;

    // Unpack the flat request buses into per-channel views.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign chan_a[gi]  = req_a[gi*REG_SIZE +: REG_SIZE];
            assign chan_b[gi]  = req_b[gi*REG_SIZE +: REG_SIZE];
            assign chan_op[gi] = req_op[gi*OP_BITS +: OP_BITS];
        end
    endgenerate

    // First valid channel at or above rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (CH_BITS+1)'(k);
            if (scan_idx >= CH_COUNT) begin
                scan_idx = scan_idx - CH_COUNT;
            end
            if (!grant_found && req_valid[scan_idx[CH_BITS-1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = scan_idx[CH_BITS-1:0];
            end
        end
    end

    assign space   = (count_reg < FIFO_FULL);
    // Gated by rst so req_ready reads zero throughout an asserted reset.
    assign accept  = !rst && (state_reg == IDLE) && space && grant_found;
    assign rr_next = (grant_ch == LAST_CH) ? '0 : grant_ch + 1'b1;
    assign push    = (state_reg == WAIT) && core_ready;
    assign pop     = rsp_valid && rsp_ready;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_ch == CH_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            cur_ch_reg     <= '0;
            core_start_reg <= 1'b0;
            core_a_reg     <= '0;
            core_b_reg     <= '0;
            core_op_reg    <= '0;
        end else begin
            core_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        core_a_reg     <= chan_a[grant_ch];
                        core_b_reg     <= chan_b[grant_ch];
                        core_op_reg    <= chan_op[grant_ch];
                        cur_ch_reg     <= grant_ch;
                        rr_ptr_reg     <= rr_next;
                        core_start_reg <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (core_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Result queue; storage is cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr_reg] <= {cur_ch_reg, core_res};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_BITS'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_BITS'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign rsp_valid  = (count_reg != '0);
    assign rsp_res    = head_entry[REG_SIZE-1:0];
    assign rsp_ch     = head_entry[ENTRY_W-1:REG_SIZE];

    assign core_start = core_start_reg;
    assign core_a     = core_a_reg;
    assign core_b     = core_b_reg;
    assign core_op    = core_op_reg;
    assign busy       = (state_reg != IDLE);

endmodule
